// File: rtl/cl_result_packer_pkg.sv
// Shared widths, slot-count sizing and FSM state type for the cache-line result packer.
// Every file that needs these pulls them in with import cl_result_packer_pkg::*.
package cl_result_packer_pkg;

  localparam int CL_DATA_WIDTH  = 512;
  localparam int RESULT_WIDTH   = 32;
  localparam int FIFO_WIDTH     = 20;
  localparam int COUNT_WIDTH    = 65;
  localparam int RESULTS_PER_CL = CL_DATA_WIDTH / RESULT_WIDTH;
  localparam int CNT_WIDTH      = $clog2(RESULTS_PER_CL) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [RESULT_WIDTH-1:0] result_t;

  // The upper slot bits above a FIFO word are always forced to zero.
  function automatic result_t padResult(input logic [FIFO_WIDTH-1:0] word);
    return {{(RESULT_WIDTH - FIFO_WIDTH){1'b0}}, word};
  endfunction

endpackage

// File: rtl/cl_result_packer_if.sv
// Control, FIFO-read and DMA-write signals of the result packer, bundled together.
// The slave modport is the packer's own view; the master modport is the view of whatever drives it.
interface cl_result_packer_if;
  import cl_result_packer_pkg::*;

  logic                     go;
  logic [COUNT_WIDTH-1:0]   num_lines;
  logic                     fifo_empty;
  logic [FIFO_WIDTH-1:0]    fifo_rd_data;
  logic                     fifo_rd_en;
  logic                     wr_full;
  logic                     wr_en;
  logic [CL_DATA_WIDTH-1:0] wr_data;
  logic [COUNT_WIDTH-1:0]   lines_written;
  logic                     busy;
  logic                     done;

  modport slave (
    input  go, num_lines, fifo_empty, fifo_rd_data, wr_full,
    output fifo_rd_en, wr_en, wr_data, lines_written, busy, done
  );

  modport master (
    output go, num_lines, fifo_empty, fifo_rd_data, wr_full,
    input  fifo_rd_en, wr_en, wr_data, lines_written, busy, done
  );

endinterface

// File: rtl/cl_result_packer.sv
// Packs zero-extended FIFO words into 512-bit lines and writes a programmed number of lines to DMA.
// A full line waits in the shift buffer until the write channel accepts it.
module cl_result_packer
  import cl_result_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cl_result_packer_if.slave bus
);

  state_t                   r_state;
  state_t                   w_nextState;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic [CL_DATA_WIDTH-1:0] r_buf;
  logic [COUNT_WIDTH-1:0]   r_linesWritten;
  logic [COUNT_WIDTH-1:0]   r_target;

  logic w_fill;
  logic w_lineFull;
  logic w_wrEn;
  logic w_rdEn;
  logic w_terminal;
  logic w_goAccept;

  // The terminal write blocks the pop in the same cycle, so the FIFO is never read past the last line.
  always_comb begin
    w_nextState = r_state;
    w_fill      = (r_state == FILL);
    w_lineFull  = (r_cnt == CNT_WIDTH'(RESULTS_PER_CL));
    w_wrEn      = w_fill && w_lineFull && !bus.wr_full;
    w_terminal  = w_wrEn && ((r_linesWritten + COUNT_WIDTH'(1)) == r_target);
    w_rdEn      = w_fill && !bus.fifo_empty && (!w_lineFull || w_wrEn) && !w_terminal;
    w_goAccept  = bus.go && (r_state != FILL);

    case (r_state)
      IDLE, DONE: begin
        if (w_goAccept) begin
          w_nextState = (bus.num_lines != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (w_terminal) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A write and a pop in one cycle leave exactly one result in the new line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_buf          <= '0;
      r_linesWritten <= '0;
      r_target       <= '0;
    end else begin
      if (w_goAccept) begin
        r_cnt          <= '0;
        r_linesWritten <= '0;
        r_target       <= bus.num_lines;
      end else begin
        if (w_rdEn && w_wrEn) begin
          r_cnt <= CNT_WIDTH'(1);
        end else if (w_wrEn) begin
          r_cnt <= '0;
        end else if (w_rdEn) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        if (w_wrEn) begin
          r_linesWritten <= r_linesWritten + COUNT_WIDTH'(1);
        end
      end
      if (w_rdEn) begin
        r_buf <= {padResult(bus.fifo_rd_data), r_buf[CL_DATA_WIDTH-1:RESULT_WIDTH]};
      end
    end
  end

  assign bus.fifo_rd_en    = w_rdEn;
  assign bus.wr_en         = w_wrEn;
  assign bus.wr_data       = r_buf;
  assign bus.lines_written = r_linesWritten;
  assign bus.busy          = (r_state == FILL);
  assign bus.done          = (r_state == DONE);

endmodule

// File: tb/tb_cl_result_packer.sv
// Directed bench for cl_result_packer: a small FIFO model feeds words, a sampler records pops and writes.
// Expected lines are rebuilt from the loaded FIFO words, one 32-bit slot per word.
module tb_cl_result_packer;
  import cl_result_packer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   popTotal = 0;
  logic toggleBit = 1'b0;

  cl_result_packer_if dut_if ();

  cl_result_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;
  always @(posedge clk) toggleBit <= ~toggleBit;
  always @(posedge clk) if (dut_if.fifo_rd_en) popTotal <= popTotal + 1;

  // FIFO model: head is the number of pops since the last load.
  logic [FIFO_WIDTH-1:0] fifoMem [0:63];
  int   fifoBase = 0;
  int   fifoLen = 0;
  int   fifoIdx;
  logic forceEmpty = 1'b1;
  logic toggleMode = 1'b0;

  assign fifoIdx = popTotal - fifoBase;
  assign dut_if.fifo_rd_data = (fifoIdx >= 0 && fifoIdx < fifoLen) ? fifoMem[fifoIdx[5:0]] : '0;
  assign dut_if.fifo_empty = forceEmpty || (fifoIdx >= fifoLen) || (toggleMode && toggleBit);

  int vectors = 0;
  int miscompares = 0;
  int popCount, writeCount, badPops, firstPopCycle, goCycle;
  int writeCycle [0:3];
  logic [CL_DATA_WIDTH-1:0] writeData [0:3];
  logic [CL_DATA_WIDTH-1:0] snapshot;

  task automatic checkOutput(input string tag, input logic [CL_DATA_WIDTH-1:0] observed,
                             input logic [CL_DATA_WIDTH-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sample the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic stepCycle();
    @(negedge clk);
    if (dut_if.fifo_rd_en) begin
      if (popCount == 0) firstPopCycle = cycle;
      if (dut_if.fifo_empty) badPops++;
      popCount++;
    end
    if (dut_if.wr_en) begin
      if (writeCount < 4) begin
        writeCycle[writeCount] = cycle;
        writeData[writeCount]  = dut_if.wr_data;
      end
      writeCount++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearMonitor();
    popCount = 0;
    writeCount = 0;
    badPops = 0;
    firstPopCycle = -1;
    for (int i = 0; i < 4; i++) begin
      writeCycle[i] = -1;
      writeData[i]  = '0;
    end
  endtask

  task automatic loadFifo(input int firstWord, input int count, input logic constant);
    fifoBase = popTotal;
    fifoLen = count;
    for (int i = 0; i < count; i++) begin
      fifoMem[i] = constant ? 20'hFFFFF : 20'(firstWord + i);
    end
  endtask

  task automatic applyStimulus(input int lines);
    dut_if.go = 1'b1;
    dut_if.num_lines = COUNT_WIDTH'(lines);
    goCycle = cycle;
    stepCycle();
    dut_if.go = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (!dut_if.done && k < budget) begin
      stepCycle();
      k++;
    end
    checkOutput("done_reached", 512'(dut_if.done), 512'(1));
  endtask

  function automatic logic [CL_DATA_WIDTH-1:0] lineOf(input int firstWord);
    logic [CL_DATA_WIDTH-1:0] l;
    for (int k = 0; k < RESULTS_PER_CL; k++) begin
      l[RESULT_WIDTH*k +: RESULT_WIDTH] = {12'h000, 20'(firstWord + k)};
    end
    return l;
  endfunction

  initial begin
    rst = 1'b1;
    dut_if.go = 1'b0;
    dut_if.num_lines = '0;
    dut_if.wr_full = 1'b0;
    clearMonitor();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_data", dut_if.wr_data, '0);
    checkOutput("rst_strobes", 512'({dut_if.wr_en, dut_if.fifo_rd_en, dut_if.busy, dut_if.done}), 512'(0));
    checkOutput("rst_lines_written", 512'(dut_if.lines_written), 512'(0));
    rst = 1'b0;
    stepCycle();

    $display("[TB] two lines, continuous FIFO");
    loadFifo(0, 48, 1'b0);
    forceEmpty = 1'b0;
    clearMonitor();
    applyStimulus(2);
    checkOutput("busy_after_go", 512'(dut_if.busy), 512'(1));
    waitDone(100);
    checkOutput("write_count", 512'(writeCount), 512'(2));
    checkOutput("first_pop_cycle", 512'(firstPopCycle), 512'(goCycle + 1));
    checkOutput("write_spacing", 512'(writeCycle[1] - writeCycle[0]), 512'(16));
    checkOutput("done_cycle", 512'(cycle), 512'(writeCycle[1] + 1));
    checkOutput("line0", writeData[0], lineOf(0));
    checkOutput("line1", writeData[1], lineOf(16));
    checkOutput("lines_written_2", 512'(dut_if.lines_written), 512'(2));
    checkOutput("pop_count_32", 512'(popCount), 512'(32));
    checkOutput("busy_in_done", 512'(dut_if.busy), 512'(0));

    $display("[TB] all-ones FIFO words");
    loadFifo(0, 16, 1'b1);
    clearMonitor();
    applyStimulus(1);
    waitDone(100);
    checkOutput("ones_line", writeData[0], {RESULTS_PER_CL{32'h000FFFFF}});

    $display("[TB] write channel stall");
    loadFifo(0, 48, 1'b0);
    clearMonitor();
    dut_if.wr_full = 1'b1;
    applyStimulus(2);
    for (int i = 0; i < 16; i++) stepCycle();
    checkOutput("stall_no_wr", 512'(dut_if.wr_en), 512'(0));
    checkOutput("stall_no_pop", 512'(dut_if.fifo_rd_en), 512'(0));
    checkOutput("stall_line", dut_if.wr_data, lineOf(0));
    snapshot = dut_if.wr_data;
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("stall_stable", dut_if.wr_data, snapshot);
    checkOutput("stall_no_pop_end", 512'(dut_if.fifo_rd_en), 512'(0));
    stepCycle();
    checkOutput("stall_pops_16", 512'(popCount), 512'(16));
    dut_if.wr_full = 1'b0;
    #1;
    checkOutput("release_wr", 512'(dut_if.wr_en), 512'(1));
    checkOutput("release_pop", 512'(dut_if.fifo_rd_en), 512'(1));
    stepCycle();
    checkOutput("release_cycle", 512'(writeCycle[0]), 512'(goCycle + 22));
    checkOutput("slot15_new_word", 512'(dut_if.wr_data[511:480]), 512'(16));
    waitDone(100);
    checkOutput("stall_line0", writeData[0], lineOf(0));
    checkOutput("stall_line1", writeData[1], lineOf(16));

    $display("[TB] zero lines requested");
    clearMonitor();
    applyStimulus(0);
    checkOutput("zero_done", 512'(dut_if.done), 512'(1));
    checkOutput("zero_busy", 512'(dut_if.busy), 512'(0));
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("zero_pops", 512'(popCount), 512'(0));
    checkOutput("zero_writes", 512'(writeCount), 512'(0));
    checkOutput("zero_lines_written", 512'(dut_if.lines_written), 512'(0));

    $display("[TB] reset mid-line");
    loadFifo(100, 32, 1'b0);
    clearMonitor();
    applyStimulus(1);
    for (int i = 0; i < 7; i++) stepCycle();
    checkOutput("pre_reset_pops", 512'(popCount), 512'(7));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_wr_data", dut_if.wr_data, '0);
    checkOutput("mid_rst_strobes", 512'({dut_if.wr_en, dut_if.fifo_rd_en, dut_if.busy, dut_if.done}), 512'(0));
    checkOutput("mid_rst_lines_written", 512'(dut_if.lines_written), 512'(0));
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("mid_rst_no_write", 512'(writeCount), 512'(0));
    loadFifo(200, 32, 1'b0);
    clearMonitor();
    applyStimulus(1);
    waitDone(100);
    checkOutput("post_rst_line", writeData[0], lineOf(200));
    checkOutput("post_rst_writes", 512'(writeCount), 512'(1));

    $display("[TB] toggling empty, go during fill");
    loadFifo(300, 48, 1'b0);
    toggleMode = 1'b1;
    clearMonitor();
    applyStimulus(1);
    for (int i = 0; i < 5; i++) stepCycle();
    dut_if.go = 1'b1;
    dut_if.num_lines = COUNT_WIDTH'(5);
    stepCycle();
    dut_if.go = 1'b0;
    waitDone(200);
    checkOutput("toggle_writes", 512'(writeCount), 512'(1));
    checkOutput("toggle_line", writeData[0], lineOf(300));
    checkOutput("toggle_pops", 512'(popCount), 512'(16));
    checkOutput("toggle_bad_pops", 512'(badPops), 512'(0));
    checkOutput("toggle_lines_written", 512'(dut_if.lines_written), 512'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cl_result_packer.md
# cl_result_packer

Packs the ring-oscillator sample stream into 512-bit cache lines for the DMA write channel. It sits between the ro_top absorption FIFO, a first-word-fall-through FIFO, and the dma write port. It zero-extends each FIFO word to a 32-bit result and emits one write per 16 results. It stops after a software-programmed number of lines and reports completion.

## Interface
- CL_DATA_WIDTH, 512, cache-line width in bits
- RESULT_WIDTH, 32, width of one packed result slot
- FIFO_WIDTH, 20, width of one FIFO word; must be ≤ RESULT_WIDTH
- COUNT_WIDTH, 65, width of the line-count and written-count fields
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- go  in  1  single-cycle start pulse; honoured only in IDLE or DONE
- num_lines  in  COUNT_WIDTH  number of lines to write; sampled on an accepted go
- fifo_empty  in  1  FIFO has no data
- fifo_rd_data  in  FIFO_WIDTH  head-of-FIFO word, valid while !fifo_empty
- fifo_rd_en  out  1  pops the FIFO head this cycle
- wr_full  in  1  DMA write channel cannot accept data
- wr_en  out  1  DMA write strobe
- wr_data  out  CL_DATA_WIDTH  line being written
- lines_written  out  COUNT_WIDTH  lines accepted since the last go
- busy  out  1  high in FILL
- done  out  1  high in DONE

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - go with num_lines≠0 → FILL; go with num_lines=0 → DONE.
  - On an accepted go: clear slot count, clear lines_written, latch num_lines into target.
- FILL, slot count cnt 0..16:
  - fifo_rd_en = !fifo_empty && (cnt<16 || wr_en).
  - wr_en = (cnt==16) && !wr_full.
- On each pop: buf ← {zero-extended fifo_rd_data, buf[CL_DATA_WIDTH-1:RESULT_WIDTH]}. The first popped result therefore ends in bits [31:0] and the 16th in bits [511:480].
- cnt update:
  - pop only: cnt+1.
  - wr_en only: cnt←0.
  - wr_en and pop in the same cycle: cnt←1. buf shifts normally; the written line was already captured on wr_data that cycle.
- On wr_en: lines_written+1. If lines_written+1==target, next state is DONE and no pop occurs that cycle. fifo_rd_en is gated by the terminal write, so the FIFO is never drained beyond 16·target words.
- DONE:
  - done held high.
  - fifo_rd_en and wr_en stay low.
  - go restarts using the same rules as IDLE. lines_written holds until then.
- go during FILL is ignored and has no effect on counters.
- Upper bits [RESULT_WIDTH-1:FIFO_WIDTH] of every slot are always 0.

## Timing
- Reset values:
  - state=IDLE, cnt=0, buf=0, lines_written=0, target=0.
  - wr_data=0, fifo_rd_en=0, wr_en=0, busy=0, done=0.
- Reset mid-operation returns to IDLE immediately. Partial lines are discarded and no write is issued.
- go at cycle t → busy=1 at t+1. The first pop can occur at t+1.
- fifo_rd_en and wr_en are combinational from registered state and the inputs fifo_empty and wr_full. No combinational path exists from fifo_rd_data.
- 16th pop at cycle t → wr_en at t+1 if !wr_full. Otherwise wr_en is held off and wr_data stays stable until the cycle wr_full falls.
- Sustained throughput with an always-non-empty FIFO and never-full DMA: one line per 16 cycles, with no bubble at line boundaries.
- Terminal wr_en at cycle t → done=1 and busy=0 at t+1.
- lines_written updates in the cycle after each wr_en.

## Structure
- A shared package holds:
  - CL_DATA_WIDTH, RESULT_WIDTH, RESULTS_PER_CL = CL_DATA_WIDTH/RESULT_WIDTH, and the slot-count width $clog2(RESULTS_PER_CL)+1.
  - The state enum {IDLE, FILL, DONE}.
- Single module; no sub-module. The shift buffer, counters and FSM are small enough to stay flat.

## Test plan
- num_lines=2, FIFO words 0..31 always available, wr_full=0:
  - Exactly 2 wr_en pulses, 16 cycles apart.
  - Line 0 holds slot k = k; line 1 holds slot k = 16+k.
  - done at the cycle after the 2nd write; lines_written=2; exactly 32 pops.
- FIFO word 0xFFFFF:
  - Each slot reads 0x000FFFFF; bits [31:20] of every slot are 0.
- wr_full high for 5 cycles after the 16th pop, with FIFO non-empty:
  - wr_en delayed 5 cycles and wr_data stable throughout; no pop while cnt=16.
  - On release: write and pop in the same cycle, and the new word lands in slot 15 of the next line.
- go with num_lines=0:
  - done at t+1; no pops, no writes; lines_written=0.
- rst asserted after 7 pops of line 0:
  - All outputs return to reset values immediately.
  - A subsequent go with num_lines=1 produces a line containing only the 16 post-go words.
- go pulses during FILL, and fifo_empty toggling every cycle:
  - go ignored.
  - Pops occur only on non-empty cycles; line contents are in pop order; 16 pops per line.
